// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared state encoding and bus constants for the I2C target
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// i2c_line_sync : SCL/SDA synchroniser with edge, START and STOP strobes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Flops reset high so a reset never fabricates an edge on an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda    = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise = w_scl & ~r_scl_prev;
    assign scl_fall = ~w_scl & r_scl_prev;
    assign start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev;
    assign stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev;
    assign sda      = w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_rx.sv
// ============================================================================
// i2c_slave_rx : 7-bit addressed I2C target with byte write/read interface
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addr_hit,
    output logic       rw
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start    (w_start),
        .stop     (w_stop),
        .sda      (w_sda)
    );

    state_t     r_state,     w_state;
    logic [2:0] r_cnt,       w_cnt;
    logic [6:0] r_shift,     w_shift;
    logic [7:0] r_tx_shift,  w_tx_shift;
    logic [7:0] r_rx_data,   w_rx_data;
    logic       r_byte_done, w_byte_done;
    logic       r_match,     w_match;
    logic       r_sda_oe,    w_sda_oe;
    logic       r_rx_valid,  w_rx_valid;
    logic       r_tx_req,    w_tx_req;
    logic       r_busy,      w_busy;
    logic       r_addr_hit,  w_addr_hit;
    logic       r_rw,        w_rw;
    logic [7:0] w_shift_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_rx_data   <= 8'd0;
            r_byte_done <= 1'b0;
            r_match     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_rw        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift     <= w_shift;
            r_tx_shift  <= w_tx_shift;
            r_rx_data   <= w_rx_data;
            r_byte_done <= w_byte_done;
            r_match     <= w_match;
            r_sda_oe    <= w_sda_oe;
            r_rx_valid  <= w_rx_valid;
            r_tx_req    <= w_tx_req;
            r_busy      <= w_busy;
            r_addr_hit  <= w_addr_hit;
            r_rw        <= w_rw;
        end
    end

    assign w_shift_in = {r_shift, w_sda};

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_shift     = r_shift;
        w_tx_shift  = r_tx_shift;
        w_rx_data   = r_rx_data;
        w_byte_done = r_byte_done;
        w_match     = r_match;
        w_sda_oe    = r_sda_oe;
        w_rx_valid  = 1'b0;
        w_tx_req    = 1'b0;
        w_busy      = r_busy;
        w_addr_hit  = 1'b0;
        w_rw        = r_rw;

        if (w_start) begin
            w_state     = ADDR;
            w_cnt       = 3'd0;
            w_sda_oe    = 1'b0;
            w_busy      = 1'b0;
            w_byte_done = 1'b0;
        end else if (w_stop) begin
            w_state     = IDLE;
            w_sda_oe    = 1'b0;
            w_busy      = 1'b0;
            w_byte_done = 1'b0;
        end else begin
            unique case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift = w_shift_in[6:0];
                        w_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_byte_done = 1'b1;
                            w_match     = (w_shift_in[7:1] == SLAVE_ADDR);
                            if (w_shift_in[7:1] == SLAVE_ADDR) begin
                                w_rw       = w_shift_in[0];
                                w_addr_hit = 1'b1;
                                w_busy     = 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done = 1'b0;
                        w_state     = r_match ? ADDR_ACK : IGNORE;
                        w_sda_oe    = r_match;
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_rise && r_rw == I2C_RW_READ) begin
                        w_tx_req = 1'b1;
                    end else if (w_scl_fall) begin
                        w_cnt = 3'd0;
                        if (r_rw == I2C_RW_READ) begin
                            w_tx_shift = tx_data;
                            w_sda_oe   = ~tx_data[7];
                            w_state    = RD_DATA;
                        end else begin
                            w_sda_oe = 1'b0;
                            w_state  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift = w_shift_in[6:0];
                        w_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_data   = w_shift_in;
                            w_rx_valid  = 1'b1;
                            w_byte_done = 1'b1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done = 1'b0;
                        w_sda_oe    = 1'b1;
                        w_state     = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe = 1'b0;
                        w_cnt    = 3'd0;
                        w_state  = WR_DATA;
                    end
                end
                // r_cnt counts bits already clocked out, so ~r_cnt indexes the next one.
                RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_byte_done = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_byte_done) begin
                            w_byte_done = 1'b0;
                            w_sda_oe    = 1'b0;
                            w_state     = RD_ACK;
                        end else begin
                            w_sda_oe = ~r_tx_shift[~r_cnt];
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == I2C_ACK) begin
                            w_tx_req = 1'b1;
                        end else begin
                            w_busy  = 1'b0;
                            w_state = IGNORE;
                        end
                    end else if (w_scl_fall) begin
                        w_tx_shift = tx_data;
                        w_sda_oe   = ~tx_data[7];
                        w_cnt      = 3'd0;
                        w_state    = RD_DATA;
                    end
                end
                IGNORE: begin
                    w_sda_oe = 1'b0;
                end
                default: begin
                    w_state = r_state;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign addr_hit = r_addr_hit;
    assign rw       = r_rw;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
// ============================================================================
// tb_i2c_slave_rx : bus-level master model driving the I2C target
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_slave_rx;
    import i2c_pkg::*;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       sda_line;
    logic       sda_oe, rx_valid, tx_req, busy, addr_hit, rw;
    logic [7:0] rx_data;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .addr_hit (addr_hit),
        .rw       (rw)
    );

    int         checks = 0;
    int         errors = 0;
    int         n_rx, n_hit, n_txreq;
    bit         oe_seen;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    // Observer plus read-byte responder: hands out the next queued byte on tx_req.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin n_rx++; rx_q.push_back(rx_data); end
            if (addr_hit) n_hit++;
            if (sda_oe) oe_seen = 1'b1;
            if (tx_req) begin
                n_txreq++;
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        n_rx = 0; n_hit = 0; n_txreq = 0; oe_seen = 1'b0;
        rx_q.delete();
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;   tick(4);
        scl_m = 1'b1; tick(4);
        s = sda_line; tick(4);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(4);
        scl_m = 1'b1; tick(4);
        sda_m = 1'b0; tick(4);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(4);
        scl_m = 1'b1; tick(4);
        sda_m = 1'b1; tick(8);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(mack, s);
    endtask

    function automatic logic exp_ack(input logic [7:0] a);
        return (a[7:1] == SLAVE_ADDR) ? I2C_ACK : I2C_NACK;
    endfunction

    initial begin
        logic       ack;
        logic [7:0] d, a, b0, b1;
        logic [7:0] wq[$];

        tick(3);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_flags", {rx_valid, tx_req, busy, addr_hit, rw}, 0);
        rst_n = 1'b1;
        tick(3);

        // Write: address 0xA0, data 0x3C then a random byte
        clr();
        wq = '{8'h3C, 8'($urandom)};
        i2c_start();
        send_byte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'(exp_ack(8'hA0)));
        chk("wr_addr_hit", n_hit, 1);
        chk("wr_rw", 32'(rw), 0);
        chk("wr_busy", 32'(busy), 1);
        foreach (wq[i]) begin
            send_byte(wq[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        end
        i2c_stop();
        chk("wr_rx_count", n_rx, wq.size());
        foreach (wq[i]) if (i < rx_q.size()) chk("wr_rx_data", 32'(rx_q[i]), 32'(wq[i]));
        chk("wr_busy_after_stop", 32'(busy), 0);

        // Mismatched address with random R/W
        clr();
        a = {7'($urandom_range(0, 127)), 1'($urandom)};
        if (a[7:1] == SLAVE_ADDR) a[7:1] = 7'h42;
        i2c_start();
        send_byte(a, ack);
        chk("mm_addr_nack", 32'(ack), 32'(exp_ack(a)));
        chk("mm_state", 32'(dut.r_state), 32'(IGNORE));
        send_byte(8'($urandom), ack);
        chk("mm_data_nack", 32'(ack), 32'(I2C_NACK));
        chk("mm_state_hold", 32'(dut.r_state), 32'(IGNORE));
        chk("mm_oe_seen", 32'(oe_seen), 0);
        chk("mm_hits", n_hit + n_rx, 0);
        i2c_stop();
        chk("mm_idle", 32'(dut.r_state), 32'(IDLE));

        // Reads: fixed pair, then a random pair; first ACKed, second NACKed
        for (int k = 0; k < 2; k++) begin
            clr();
            b0 = (k == 0) ? 8'hC5 : 8'($urandom);
            b1 = (k == 0) ? 8'h81 : 8'($urandom);
            tx_q = '{b0, b1};
            i2c_start();
            send_byte(8'hA1, ack);
            chk("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
            chk("rd_rw", 32'(rw), 32'(I2C_RW_READ));
            recv_byte(d, I2C_ACK);
            chk("rd_byte0", 32'(d), 32'(b0));
            recv_byte(d, I2C_NACK);
            chk("rd_byte1", 32'(d), 32'(b1));
            chk("rd_busy_after_nack", 32'(busy), 0);
            chk("rd_tx_req", n_txreq, 2);
            i2c_stop();
        end

        // Repeated START after 4 data bits, then a read
        clr();
        i2c_start();
        send_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), ack);
        b0 = 8'($urandom);
        tx_q = '{b0};
        i2c_start();
        send_byte(8'hA1, ack);
        chk("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
        chk("rs_rw", 32'(rw), 1);
        recv_byte(d, I2C_NACK);
        chk("rs_byte", 32'(d), 32'(b0));
        chk("rs_no_rx", n_rx, 0);
        i2c_stop();

        // Asynchronous reset while driving a zero bit in RD_DATA
        clr();
        b0 = 8'($urandom) & 8'h7F;
        tx_q = '{b0};
        i2c_start();
        send_byte(8'hA1, ack);
        chk("ar_state", 32'(dut.r_state), 32'(RD_DATA));
        chk("ar_oe_before", 32'(sda_oe), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("ar_oe_async", 32'(sda_oe), 0);
        chk("ar_busy_async", 32'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 9; i++) bit_xfer(1'b1, ack);
        chk("ar_ignored_oe", 32'(oe_seen), 0);
        chk("ar_ignored_hit", n_hit, 0);
        chk("ar_state_idle", 32'(dut.r_state), 32'(IDLE));
        i2c_stop();

        // STOP straight after the address ACK
        clr();
        i2c_start();
        send_byte(8'hA0, ack);
        chk("sp_addr_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        chk("sp_state", 32'(dut.r_state), 32'(IDLE));
        chk("sp_busy", 32'(busy), 0);
        chk("sp_no_rx", n_rx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
